// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin scheduler for the shared register write bus.
// N_REQ requesters compete for one DATA_W write bus. Each grant drives a
// one-hot load enable into the register bank one cycle after arbitration.
// Optional feature macro: REG_ARB_R0_PROTECT_EN (register 0 hardwired zero).
module reg_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [NUM_REGS-1:0]       reg_en,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      busy,
    output logic                      err
);

    localparam int          PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned NR    = N_REQ;
    localparam int unsigned NREGS = NUM_REGS;

    logic [PTR_W-1:0]    rr_ptr;
    logic [N_REQ-1:0]    elig;
    logic                win_found;
    logic [PTR_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                addr_ok;
    logic                r0_hit;
    logic [N_REQ-1:0]    nxt_gnt;
    logic [NUM_REGS-1:0] nxt_reg_en;
    int unsigned         cand;

    // Round-robin search starting just after the last winner; a requester
    // currently holding its grant pulse is masked out for this cycle.
    always_comb begin
        elig      = req & ~gnt;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            cand = (32'(rr_ptr) + k) % NR;
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    // Decode the winner's slices into the next grant and load-enable vectors.
    always_comb begin
        win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
        win_data = req_data[win_idx*DATA_W +: DATA_W];
        addr_ok  = (32'(win_addr) < NREGS);
`ifdef REG_ARB_R0_PROTECT_EN
        r0_hit   = (win_addr == '0);
`else
        r0_hit   = 1'b0;
`endif
        nxt_gnt    = '0;
        nxt_reg_en = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            nxt_gnt[i] = win_found && (32'(win_idx) == i);
        end
        for (int unsigned r = 0; r < NREGS; r++) begin
            nxt_reg_en[r] = win_found && addr_ok && !r0_hit && (32'(win_addr) == r);
        end
    end

    // Output and pointer registers; bus_out and rr_ptr hold when nobody wins.
    always_ff @(posedge clk) begin
        if (!clr) begin
            gnt     <= '0;
            reg_en  <= '0;
            bus_out <= '0;
            err     <= 1'b0;
            rr_ptr  <= PTR_W'(N_REQ - 1);
        end else if (win_found) begin
            gnt     <= nxt_gnt;
            reg_en  <= nxt_reg_en;
            bus_out <= win_data;
            err     <= !addr_ok;
            rr_ptr  <= win_idx;
        end else begin
            gnt     <= '0;
            reg_en  <= '0;
            err     <= 1'b0;
        end
    end

    assign busy = |gnt;

endmodule
